// File: rtl/segment7_scan.sv
// segment7_scan: multiplexed hex driver for 7-segment digit arrays
// with prescaled refresh, PWM brightness, blanking and polarity.
module segment7_scan #(
    parameter int DIGITS            = 4,
    parameter int DIV               = 1024,
    parameter int BRIGHT_W          = 4,
    parameter bit ANODE_ACTIVE_HIGH = 1'b1,
    parameter bit SEG_ACTIVE_HIGH   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     anodes,
    output logic [6:0]            segments,
    output logic                  dot,
    output logic                  frame_tick
);

    localparam int PW = $clog2(DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = PW + BRIGHT_W + 2;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF =
        ANODE_ACTIVE_HIGH ? {DIGITS{1'b0}} : {DIGITS{1'b1}};
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_HIGH ? 7'h00 : 7'h7F;
    localparam logic DOT_OFF = ~SEG_ACTIVE_HIGH;

    logic [PW-1:0]       pre;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] stg_data;
    logic [DIGITS-1:0]   stg_dp;
    logic [4*DIGITS-1:0] disp_data;
    logic [DIGITS-1:0]   disp_dp;
    logic                frame_end;
    logic [3:0]          nib;
    logic                dp_sel;
    logic                blank_sel;
    logic [DIGITS-1:0]   lz;
    logic                run;
    logic                on;
    logic [CW-1:0]       duty_lhs;
    logic [CW-1:0]       duty_rhs;
    logic [DIGITS-1:0]   an_raw;
    logic [6:0]          seg_raw;
    logic                dot_raw;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        unique case (v)
            4'h0: g = 7'h7E;
            4'h1: g = 7'h30;
            4'h2: g = 7'h6D;
            4'h3: g = 7'h79;
            4'h4: g = 7'h33;
            4'h5: g = 7'h5B;
            4'h6: g = 7'h5F;
            4'h7: g = 7'h70;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h7B;
            4'hA: g = 7'h77;
            4'hB: g = 7'h1F;
            4'hC: g = 7'h4E;
            4'hD: g = 7'h3D;
            4'hE: g = 7'h4F;
            default: g = 7'h47;
        endcase
        return g;
    endfunction

    assign frame_end = (pre == PRE_MAX) && (idx == IDX_MAX);

    // Slot prescaler and digit index; idx wraps after the last digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_MAX) begin
            pre <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Staging takes any load; display copies old staging only at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_data  <= '0;
            stg_dp    <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
        end else begin
            if (load) begin
                stg_data <= data;
                stg_dp   <= dp;
            end
            if (frame_end) begin
                disp_data <= stg_data;
                disp_dp   <= stg_dp;
            end
        end
    end

    // Select the current digit, its blanking state and PWM gate.
    always_comb begin
        nib       = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        run       = 1'b1;
        lz        = '0;
        an_raw    = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run   = run & (disp_data[4*k +: 4] == 4'h0);
            lz[k] = run;
        end
        duty_lhs = CW'(pre) << BRIGHT_W;
        duty_rhs = (CW'(brightness) + CW'(1)) * CW'(DIV);
        on       = duty_lhs < duty_rhs;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib       = disp_data[4*k +: 4];
                dp_sel    = disp_dp[k];
                blank_sel = lz[k];
                an_raw[k] = on;
            end
        end
        seg_raw = (on && !(blank_lz && blank_sel)) ? glyph(nib) : 7'h00;
        dot_raw = on & dp_sel;
    end

    // Registered pin drivers with polarity applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            anodes     <= AN_OFF;
            segments   <= SEG_OFF;
            dot        <= DOT_OFF;
            frame_tick <= 1'b0;
        end else begin
            anodes     <= ANODE_ACTIVE_HIGH ? an_raw : ~an_raw;
            segments   <= SEG_ACTIVE_HIGH ? seg_raw : ~seg_raw;
            dot        <= SEG_ACTIVE_HIGH ? dot_raw : ~dot_raw;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_segment7_scan.sv
// tb_segment7_scan: three scanner configurations driven in lockstep
// and compared every cycle against a frame-level reference model.
module tb_segment7_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        blank_lz;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  br0;
    logic [3:0]  br1;
    logic [3:0]  an0, an1, an2;
    logic [6:0]  sg0, sg1, sg2;
    logic        dt0, dt1, dt2;
    logic        ft0, ft1, ft2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    segment7_scan #(.DIGITS(4), .DIV(4), .BRIGHT_W(4),
        .ANODE_ACTIVE_HIGH(1'b1), .SEG_ACTIVE_HIGH(1'b1)) u0 (
        .clk(clk), .rst(rst), .data(data), .dp(dp), .load(load),
        .blank_lz(blank_lz), .brightness(br0), .anodes(an0),
        .segments(sg0), .dot(dt0), .frame_tick(ft0));

    segment7_scan #(.DIGITS(4), .DIV(16), .BRIGHT_W(4),
        .ANODE_ACTIVE_HIGH(1'b1), .SEG_ACTIVE_HIGH(1'b1)) u1 (
        .clk(clk), .rst(rst), .data(data), .dp(dp), .load(load),
        .blank_lz(blank_lz), .brightness(br1), .anodes(an1),
        .segments(sg1), .dot(dt1), .frame_tick(ft1));

    segment7_scan #(.DIGITS(4), .DIV(4), .BRIGHT_W(4),
        .ANODE_ACTIVE_HIGH(1'b0), .SEG_ACTIVE_HIGH(1'b0)) u2 (
        .clk(clk), .rst(rst), .data(data), .dp(dp), .load(load),
        .blank_lz(blank_lz), .brightness(br0), .anodes(an2),
        .segments(sg2), .dot(dt2), .frame_tick(ft2));

    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79,
                               7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F,
                               7'h4E, 7'h3D, 7'h4F, 7'h47};
    int dv [3] = '{4, 16, 4};
    bit hi [3] = '{1'b1, 1'b1, 1'b0};

    int          cnt    [3];
    logic [15:0] stg_d  [3];
    logic [15:0] disp_d [3];
    logic [3:0]  stg_p  [3];
    logic [3:0]  disp_p [3];
    logic [3:0]  e_an   [3];
    logic [6:0]  e_sg   [3];
    logic        e_dt   [3];
    logic        e_ft   [3];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: position within the frame is cycles-since-reset arithmetic.
    task automatic model();
        for (int i = 0; i < 3; i++) begin
            int pre, idx, br, msnz;
            logic on;
            logic [3:0] nib;
            if (rst) begin
                cnt[i]    = 0;
                stg_d[i]  = '0;
                stg_p[i]  = '0;
                disp_d[i] = '0;
                disp_p[i] = '0;
                e_an[i]   = hi[i] ? 4'h0 : 4'hF;
                e_sg[i]   = hi[i] ? 7'h00 : 7'h7F;
                e_dt[i]   = !hi[i];
                e_ft[i]   = 1'b0;
            end else begin
                pre = cnt[i] % dv[i];
                idx = (cnt[i] / dv[i]) % 4;
                br  = (i == 1) ? int'(br1) : int'(br0);
                on  = (pre * 16) < ((br + 1) * dv[i]);
                nib = disp_d[i][idx*4 +: 4];
                msnz = 0;
                for (int k = 0; k < 4; k++)
                    if (disp_d[i][k*4 +: 4] != 4'h0) msnz = k;
                e_an[i] = 4'h0;
                if (on) e_an[i][idx] = 1'b1;
                e_sg[i] = (on && !(blank_lz && idx > msnz)) ? glyph[nib] : 7'h00;
                e_dt[i] = on && disp_p[i][idx];
                if (!hi[i]) begin
                    e_an[i] = ~e_an[i];
                    e_sg[i] = ~e_sg[i];
                    e_dt[i] = ~e_dt[i];
                end
                e_ft[i] = (cnt[i] % (dv[i] * 4)) == (dv[i] * 4 - 1);
                if (e_ft[i]) begin
                    disp_d[i] = stg_d[i];
                    disp_p[i] = stg_p[i];
                end
                if (load) begin
                    stg_d[i] = data;
                    stg_p[i] = dp;
                end
                cnt[i]++;
            end
        end
    endtask

    task automatic check_all();
        chk("u0.anodes", 32'(an0), 32'(e_an[0]));
        chk("u0.segments", 32'(sg0), 32'(e_sg[0]));
        chk("u0.dot", 32'(dt0), 32'(e_dt[0]));
        chk("u0.frame_tick", 32'(ft0), 32'(e_ft[0]));
        chk("u1.anodes", 32'(an1), 32'(e_an[1]));
        chk("u1.segments", 32'(sg1), 32'(e_sg[1]));
        chk("u1.dot", 32'(dt1), 32'(e_dt[1]));
        chk("u1.frame_tick", 32'(ft1), 32'(e_ft[1]));
        chk("u2.anodes", 32'(an2), 32'(e_an[2]));
        chk("u2.segments", 32'(sg2), 32'(e_sg[2]));
        chk("u2.dot", 32'(dt2), 32'(e_dt[2]));
        chk("u2.frame_tick", 32'(ft2), 32'(e_ft[2]));
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        check_all();
    endtask

    initial begin
        int ticks, lit;
        rst = 1'b1; load = 1'b0; blank_lz = 1'b0;
        data = '0; dp = '0; br0 = 4'hF; br1 = 4'hF;

        // reset held three cycles, then first active output
        repeat (3) step();
        chk("rst_an", 32'(an0), 32'h0);
        chk("rst_sg", 32'(sg0), 32'h0);
        chk("rst_ft", 32'(ft0), 32'h0);
        rst = 1'b0;
        step();
        chk("first_an", 32'(an0), 32'h1);
        chk("first_sg", 32'(sg0), 32'h7E);

        // scan order and frame tick rate
        data = 16'h1234; dp = 4'b0100; load = 1'b1;
        step();
        load = 1'b0;
        ticks = 0;
        for (int n = 0; n < 32; n++) begin
            step();
            ticks += int'(ft0);
        end
        chk("tick_rate", 32'(ticks), 32'd2);

        // tear-free update: mid-frame load, then a frame-end load
        while (cnt[0] % 16 != 6) step();
        data = 16'hABCD; load = 1'b1;
        step();
        load = 1'b0;
        while (cnt[0] % 16 != 15) step();
        data = 16'h0F0F; load = 1'b1;
        step();
        load = 1'b0;
        repeat (40) step();

        // leading-zero blanking
        blank_lz = 1'b1;
        data = 16'h0070; dp = 4'b1000; load = 1'b1;
        step();
        load = 1'b0;
        repeat (36) step();
        data = 16'h0000; dp = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        repeat (36) step();
        blank_lz = 1'b0;

        // brightness duty on the DIV=16 instance
        br1 = 4'h0;
        lit = 0;
        for (int n = 0; n < 16; n++) begin step(); lit += int'(an1 != 4'h0); end
        chk("duty_0", 32'(lit), 32'd1);
        br1 = 4'h7;
        lit = 0;
        for (int n = 0; n < 16; n++) begin step(); lit += int'(an1 != 4'h0); end
        chk("duty_7", 32'(lit), 32'd8);
        br1 = 4'hF;
        lit = 0;
        for (int n = 0; n < 16; n++) begin step(); lit += int'(an1 != 4'h0); end
        chk("duty_F", 32'(lit), 32'd16);

        // active-low polarity and mid-slot reset
        data = 16'h8888; dp = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        repeat (34) step();
        chk("low_seg8", 32'(sg2), 32'h00);
        chk("low_an_ones", 32'($countones(an2)), 32'd3);
        while (cnt[0] % 4 != 2) step();
        rst = 1'b1;
        step();
        chk("low_rst_an", 32'(an2), 32'hF);
        chk("low_rst_sg", 32'(sg2), 32'h7F);
        chk("low_rst_dt", 32'(dt2), 32'h1);
        rst = 1'b0;
        step();
        chk("low_restart", 32'(an2), 32'hE);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst  = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 5) == 0);
            if (load) begin
                data = 16'($urandom);
                if ($urandom_range(0, 1) == 1) data[15:8] = 8'h00;
                dp = 4'($urandom);
            end
            if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 31) == 0) br0 = 4'($urandom);
            if ($urandom_range(0, 31) == 0) br1 = 4'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
